// File: rtl/pipeline_ctrl_if.sv
// Control bus between the RV32I pipeline datapath and its hazard/sequencing controller.
// The master side is the controller; the slave side is the datapath (decoder, PC, stage regs).
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             imem_valid;
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic [4:0]       id_rd_addr;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             id_rf_wen;
   logic             id_is_load;
   logic             ex_redirect;
   logic             dmem_busy;

   logic             pc_en;
   logic             pc_redirect;
   logic             if_id_en;
   logic             id_valid;
   logic             ex_valid;
   logic             mem_valid;
   logic             wb_valid;
   logic [1:0]       fwd_rs1;
   logic [1:0]       fwd_rs2;
   logic             stall_load_use;
   logic [CNT_W-1:0] instret;

   modport master (
      input  imem_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
             id_use_rs1, id_use_rs2, id_rf_wen, id_is_load,
             ex_redirect, dmem_busy,
      output pc_en, pc_redirect, if_id_en,
             id_valid, ex_valid, mem_valid, wb_valid,
             fwd_rs1, fwd_rs2, stall_load_use, instret
   );

   modport slave (
      output imem_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
             id_use_rs1, id_use_rs2, id_rf_wen, id_is_load,
             ex_redirect, dmem_busy,
      input  pc_en, pc_redirect, if_id_en,
             id_valid, ex_valid, mem_valid, wb_valid,
             fwd_rs1, fwd_rs2, stall_load_use, instret
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for a 5-stage RV32I pipeline: stage valids, load-use
// stall, branch flush, EX operand forwarding selects and the retired-instruction counter.
module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pipeline_ctrl_if.master      bus
);

   localparam int ID  = 0;
   localparam int EX  = 1;
   localparam int MEM = 2;
   localparam int WB  = 3;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // EX needs source info for forwarding; MEM/WB only need to describe their write
   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use_rs1;
      logic       use_rs2;
      logic       rf_wen;
      logic       is_load;
   } ex_sh_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       rf_wen;
   } dst_t;

   logic [3:0]       r_vld;
   ex_sh_t           r_ex;
   dst_t             r_mem;
   dst_t             r_wb;
   logic [CNT_W-1:0] r_instret;

   ex_sh_t w_id;
   logic   w_adv;
   logic   w_redirect;
   logic   w_load_use;
   logic   w_mem_wr;
   logic   w_wb_wr;
   logic   w_hit_rs1;
   logic   w_hit_rs2;

   function automatic logic [1:0] fwd_sel(
      input logic       use_rs,
      input logic [4:0] rs,
      input logic       mem_wr,
      input logic [4:0] mem_rd,
      input logic       wb_wr,
      input logic [4:0] wb_rd
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (use_rs && mem_wr && (mem_rd == rs))
         sel = FWD_MEM;
      else if (use_rs && wb_wr && (wb_rd == rs))
         sel = FWD_WB;
      return sel;
   endfunction

   always_comb begin
      w_id         = '0;
      w_id.rd      = bus.id_rd_addr;
      w_id.rs1     = bus.id_rs1_addr;
      w_id.rs2     = bus.id_rs2_addr;
      w_id.use_rs1 = bus.id_use_rs1;
      w_id.use_rs2 = bus.id_use_rs2;
      w_id.rf_wen  = bus.id_rf_wen;
      w_id.is_load = bus.id_is_load;
   end

   // x0 writes are architecturally void, so they never count as producers
   assign w_mem_wr   = r_vld[MEM] & r_mem.rf_wen & (|r_mem.rd);
   assign w_wb_wr    = r_vld[WB]  & r_wb.rf_wen  & (|r_wb.rd);

   assign w_adv      = ~bus.dmem_busy;
   assign w_redirect = r_vld[EX] & bus.ex_redirect;

   assign w_hit_rs1  = bus.id_use_rs1 & (bus.id_rs1_addr == r_ex.rd);
   assign w_hit_rs2  = bus.id_use_rs2 & (bus.id_rs2_addr == r_ex.rd);
   assign w_load_use = r_vld[ID] & r_vld[EX] & r_ex.is_load & (|r_ex.rd)
                     & (w_hit_rs1 | w_hit_rs2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld     <= '0;
         r_ex      <= '0;
         r_mem     <= '0;
         r_wb      <= '0;
         r_instret <= '0;
      end else if (w_adv) begin
         r_vld[WB]  <= r_vld[MEM];
         r_vld[MEM] <= r_vld[EX];
         r_vld[EX]  <= r_vld[ID] & ~w_redirect & ~w_load_use;
         // flush beats the load-use hold; a held ID keeps its instruction
         if (w_redirect)
            r_vld[ID] <= 1'b0;
         else if (!w_load_use)
            r_vld[ID] <= bus.imem_valid;

         r_wb         <= r_mem;
         r_mem.rd     <= r_ex.rd;
         r_mem.rf_wen <= r_ex.rf_wen;
         r_ex         <= w_id;

         if (r_vld[WB])
            r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign bus.pc_redirect    = w_redirect;
   assign bus.pc_en          = w_adv & (w_redirect | (~w_load_use & bus.imem_valid));
   assign bus.if_id_en       = w_adv & ~w_load_use;
   assign bus.stall_load_use = w_load_use & ~w_redirect & w_adv;

   assign bus.id_valid  = r_vld[ID];
   assign bus.ex_valid  = r_vld[EX];
   assign bus.mem_valid = r_vld[MEM];
   assign bus.wb_valid  = r_vld[WB];
   assign bus.instret   = r_instret;

   assign bus.fwd_rs1 = fwd_sel(r_ex.use_rs1, r_ex.rs1, w_mem_wr, r_mem.rd, w_wb_wr, r_wb.rd);
   assign bus.fwd_rs2 = fwd_sel(r_ex.use_rs2, r_ex.rs2, w_mem_wr, r_mem.rd, w_wb_wr, r_wb.rd);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed instruction-stream table, stall/reset sequences,
// then random traffic against an instruction-level pipeline model.
module tb_pipeline_ctrl;
   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus();
   pipeline_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, wen, ld;
   } inst_t;

   typedef struct {
      inst_t       in;
      logic        imem, redir, busy;
      logic        pc_en, pcr, ifid;
      logic [3:0]  vld;      // {id, ex, mem, wb}
      logic [1:0]  f1, f2;
      logic        stall;
      logic [31:0] instret;
      logic        fwd_dc;   // EX holds a bubble: operand selects unused
   } vec_t;

   typedef struct packed {
      logic  v;
      inst_t i;
   } slot_t;

   int          n_chk = 0;
   int          n_pass = 0;
   vec_t        tbl[$];
   slot_t       pipe[4];
   int unsigned retired;

   function automatic inst_t ins(input int rd, input int rs1, input int rs2,
                                 input bit u1, input bit u2, input bit wen, input bit ld);
      inst_t r;
      r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
      r.u1 = u1; r.u2 = u2; r.wen = wen; r.ld = ld;
      return r;
   endfunction

   function automatic vec_t mk(input inst_t i, input bit imem, input bit redir, input bit busy,
                               input bit pc, input bit pcr, input bit ifid, input logic [3:0] vld,
                               input int f1, input int f2, input bit st, input int cnt,
                               input bit dc);
      vec_t v;
      v.in = i; v.imem = imem; v.redir = redir; v.busy = busy;
      v.pc_en = pc; v.pcr = pcr; v.ifid = ifid; v.vld = vld;
      v.f1 = 2'(f1); v.f2 = 2'(f2); v.stall = st; v.instret = 32'(cnt); v.fwd_dc = dc;
      return v;
   endfunction

   function automatic inst_t rnd_inst();
      inst_t r;
      r.rd  = 5'($urandom_range(0, 3));
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.u1  = 1'($urandom_range(0, 1));
      r.u2  = 1'($urandom_range(0, 1));
      r.wen = 1'($urandom_range(0, 1));
      r.ld  = ($urandom_range(0, 2) == 0);
      return r;
   endfunction

   // youngest older instruction (MEM before WB) writing a nonzero rs supplies it
   function automatic logic [1:0] model_fwd(input logic use_rs, input logic [4:0] rs);
      if (!use_rs) return 2'd0;
      for (int s = 2; s <= 3; s++)
         if (pipe[s].v && pipe[s].i.wen && pipe[s].i.rd != 0 && pipe[s].i.rd == rs)
            return (s == 2) ? 2'd1 : 2'd2;
      return 2'd0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic drive(input vec_t v);
      bus.imem_valid  = v.imem;
      bus.id_rs1_addr = v.in.rs1;
      bus.id_rs2_addr = v.in.rs2;
      bus.id_rd_addr  = v.in.rd;
      bus.id_use_rs1  = v.in.u1;
      bus.id_use_rs2  = v.in.u2;
      bus.id_rf_wen   = v.in.wen;
      bus.id_is_load  = v.in.ld;
      bus.ex_redirect = v.redir;
      bus.dmem_busy   = v.busy;
   endtask

   task automatic cmp(input string tag, input vec_t e);
      chk($sformatf("%s.pc_en", tag), 32'(bus.pc_en), 32'(e.pc_en));
      chk($sformatf("%s.pc_redirect", tag), 32'(bus.pc_redirect), 32'(e.pcr));
      chk($sformatf("%s.if_id_en", tag), 32'(bus.if_id_en), 32'(e.ifid));
      chk($sformatf("%s.valids", tag),
          32'({bus.id_valid, bus.ex_valid, bus.mem_valid, bus.wb_valid}), 32'(e.vld));
      chk($sformatf("%s.stall", tag), 32'(bus.stall_load_use), 32'(e.stall));
      chk($sformatf("%s.instret", tag), bus.instret, e.instret);
      if (!e.fwd_dc) begin
         chk($sformatf("%s.fwd_rs1", tag), 32'(bus.fwd_rs1), 32'(e.f1));
         chk($sformatf("%s.fwd_rs2", tag), 32'(bus.fwd_rs2), 32'(e.f2));
      end
   endtask

   task automatic run(input string tag, input vec_t v);
      drive(v);
      @(negedge clk);
      cmp(tag, v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      inst_t Z, I1, I2, I3, I4, I5, I6, I7, B1, S1, S2, T1, Z1, Z2, L0, U0, P1, P2, P3, P4;
      vec_t  e;
      logic  hz, rdr;

      Z  = '0;
      I1 = ins(1, 0, 0, 1, 0, 1, 0);  I2 = ins(2, 1, 1, 1, 1, 1, 0);
      I3 = ins(3, 0, 0, 1, 0, 1, 0);  I4 = ins(0, 0, 0, 1, 0, 1, 0);
      I5 = ins(4, 3, 0, 1, 1, 1, 0);  I6 = ins(5, 0, 0, 1, 0, 1, 1);
      I7 = ins(6, 5, 0, 1, 1, 1, 0);
      B1 = ins(0, 1, 2, 1, 1, 0, 0);  S1 = ins(8, 0, 0, 1, 0, 1, 0);
      S2 = ins(9, 0, 0, 1, 0, 1, 0);  T1 = ins(10, 0, 0, 1, 0, 1, 0);
      Z1 = ins(0, 1, 1, 1, 1, 1, 0);  Z2 = ins(7, 0, 0, 1, 1, 1, 0);
      L0 = ins(0, 0, 0, 1, 0, 1, 1);  U0 = ins(11, 0, 0, 1, 1, 1, 0);
      P1 = ins(12, 0, 0, 1, 0, 1, 0); P2 = ins(13, 12, 12, 1, 1, 1, 0);
      P3 = ins(14, 13, 12, 1, 1, 1, 0); P4 = ins(15, 14, 13, 1, 1, 1, 0);

      // reset state, checked while rst_n is still low
      drive(mk(Z, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
      #1;
      cmp("reset", mk(Z, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      //              in  im rd bz  pc pcr ifid  vld    f1 f2 st cnt dc
      // forwarding from MEM/WB, then load-use bubble
      tbl.push_back(mk(Z,  1, 0, 0,  1, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(I1, 1, 0, 0,  1, 0, 1, 4'b1000, 0, 0, 0, 0, 0));
      tbl.push_back(mk(I2, 1, 0, 0,  1, 0, 1, 4'b1100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(I3, 1, 0, 0,  1, 0, 1, 4'b1110, 1, 1, 0, 0, 0));
      tbl.push_back(mk(I4, 1, 0, 0,  1, 0, 1, 4'b1111, 0, 0, 0, 0, 0));
      tbl.push_back(mk(I5, 1, 0, 0,  1, 0, 1, 4'b1111, 0, 0, 0, 1, 0));
      tbl.push_back(mk(I6, 1, 0, 0,  1, 0, 1, 4'b1111, 2, 0, 0, 2, 0));
      tbl.push_back(mk(I7, 1, 0, 0,  0, 0, 0, 4'b1111, 0, 0, 1, 3, 0));
      tbl.push_back(mk(I7, 0, 0, 0,  0, 0, 1, 4'b1011, 0, 0, 0, 4, 1));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0101, 2, 0, 0, 5, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0010, 0, 0, 0, 6, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0001, 0, 0, 0, 6, 0));
      // taken branch squashes ID and the following fetch
      tbl.push_back(mk(Z,  1, 0, 0,  1, 0, 1, 4'b0000, 0, 0, 0, 7, 0));
      tbl.push_back(mk(B1, 1, 0, 0,  1, 0, 1, 4'b1000, 0, 0, 0, 7, 0));
      tbl.push_back(mk(S1, 1, 1, 0,  1, 1, 1, 4'b1100, 0, 0, 0, 7, 0));
      tbl.push_back(mk(S2, 1, 0, 0,  1, 0, 1, 4'b0010, 0, 0, 0, 7, 0));
      tbl.push_back(mk(T1, 0, 0, 0,  0, 0, 1, 4'b1001, 0, 0, 0, 7, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0100, 0, 0, 0, 8, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0010, 0, 0, 0, 8, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0001, 0, 0, 0, 8, 0));
      // x0 is never a producer: no forwarding, no load-use stall
      tbl.push_back(mk(Z,  1, 0, 0,  1, 0, 1, 4'b0000, 0, 0, 0, 9, 0));
      tbl.push_back(mk(Z1, 1, 0, 0,  1, 0, 1, 4'b1000, 0, 0, 0, 9, 0));
      tbl.push_back(mk(Z2, 1, 0, 0,  1, 0, 1, 4'b1100, 0, 0, 0, 9, 0));
      tbl.push_back(mk(L0, 1, 0, 0,  1, 0, 1, 4'b1110, 0, 0, 0, 9, 0));
      tbl.push_back(mk(U0, 0, 0, 0,  0, 0, 1, 4'b1111, 0, 0, 0, 9, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0111, 0, 0, 0, 10, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0011, 0, 0, 0, 11, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0001, 0, 0, 0, 12, 0));
      tbl.push_back(mk(Z,  0, 0, 0,  0, 0, 1, 4'b0000, 0, 0, 0, 13, 0));
      foreach (tbl[k]) run($sformatf("tbl%0d", k), tbl[k]);

      // full pipeline frozen by dmem_busy for three cycles, then resumes
      run("busy_h0", mk(Z,  1, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 13, 0));
      run("busy_h1", mk(P1, 1, 0, 0, 1, 0, 1, 4'b1000, 0, 0, 0, 13, 0));
      run("busy_h2", mk(P2, 1, 0, 0, 1, 0, 1, 4'b1100, 0, 0, 0, 13, 0));
      run("busy_h3", mk(P3, 1, 0, 0, 1, 0, 1, 4'b1110, 1, 1, 0, 13, 0));
      for (int k = 0; k < 3; k++)
         run($sformatf("busy_frz%0d", k), mk(P4, 1, 0, 1, 0, 0, 0, 4'b1111, 1, 2, 0, 13, 0));
      run("busy_rel0", mk(P4, 0, 0, 0, 0, 0, 1, 4'b1111, 1, 2, 0, 13, 0));
      run("busy_rel1", mk(Z,  0, 0, 0, 0, 0, 1, 4'b0111, 1, 2, 0, 14, 0));

      // asynchronous reset between clock edges
      drive(mk(Z, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst", mk(Z, 1, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(mk(Z, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // random traffic against the instruction-level model
      for (int s = 0; s < 4; s++) begin
         pipe[s].v = 1'b0;
         pipe[s].i = rnd_inst();
      end
      retired = 0;
      for (int c = 0; c < 400; c++) begin
         e.in    = pipe[0].i;
         e.imem  = ($urandom_range(0, 3) != 0);
         e.redir = ($urandom_range(0, 4) == 0);
         e.busy  = ($urandom_range(0, 6) == 0);
         rdr = pipe[1].v && e.redir;
         hz  = pipe[0].v && pipe[1].v && pipe[1].i.ld && pipe[1].i.rd != 0 &&
               ((pipe[0].i.u1 && pipe[0].i.rs1 == pipe[1].i.rd) ||
                (pipe[0].i.u2 && pipe[0].i.rs2 == pipe[1].i.rd));
         e.pc_en   = !e.busy && (rdr || (!hz && e.imem));
         e.pcr     = rdr;
         e.ifid    = !e.busy && !hz;
         e.vld     = {pipe[0].v, pipe[1].v, pipe[2].v, pipe[3].v};
         e.stall   = hz && !rdr && !e.busy;
         e.instret = retired;
         e.fwd_dc  = !pipe[1].v;
         e.f1      = model_fwd(pipe[1].i.u1, pipe[1].i.rs1);
         e.f2      = model_fwd(pipe[1].i.u2, pipe[1].i.rs2);
         run($sformatf("rnd%0d", c), e);
         if (!e.busy) begin
            if (pipe[3].v) retired++;
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (rdr || hz) pipe[1].v = 1'b0;
            if (rdr || (!hz && !e.imem)) begin
               pipe[0].v = 1'b0;
               pipe[0].i = rnd_inst();
            end else if (!hz) begin
               pipe[0].v = 1'b1;
               pipe[0].i = rnd_inst();
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
